// File: rtl/wb_burst_master.sv
// Wishbone B3 incrementing-burst master: accepts one read/write burst command,
// streams beats with a one-deep write holding register and aborts on ack timeout.
module wb_burst_master #(
    parameter int DW = 32,
    parameter int AW = 26,
    parameter int BL = 5,
    parameter int TO = 255
) (
    input  logic            sys_clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [BL-1:0]   cmd_len,
    input  logic [DW-1:0]   wdata,
    input  logic [DW/8-1:0] wsel,
    input  logic            wdata_valid,
    output logic            wdata_ready,
    output logic [DW-1:0]   rdata,
    output logic            rdata_valid,
    output logic            rdata_last,
    output logic            done,
    output logic            err,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_we_o,
    output logic [AW-1:0]   wb_addr_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic [2:0]      wb_cti_o,
    input  logic            wb_ack_i,
    input  logic [DW-1:0]   wb_dat_i
);

    localparam int SW  = DW / 8;
    localparam int TOW = (TO > 0) ? $clog2(TO + 1) : 1;
    localparam logic [TOW-1:0] TO_LAST = TOW'((TO > 0) ? TO - 1 : 0);
    localparam logic [AW-1:0]  STEP    = AW'(SW);

    typedef enum logic [1:0] {IDLE, BURST, STALL} state_t;

    state_t          state_q, state_d;
    logic            we_q, we_d;
    logic            single_q, single_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [BL-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   wdat_q, wdat_d;
    logic [SW-1:0]   wsel_q, wsel_d;
    logic            wfull_q, wfull_d;
    logic [TOW-1:0]  to_q, to_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic beat_ack, last_beat, wload, to_hit;

    assign cmd_ready   = (state_q == IDLE);
    assign wb_cyc_o    = (state_q != IDLE);
    assign wb_stb_o    = (state_q == BURST);
    assign wb_we_o     = wb_cyc_o & we_q;
    assign wb_addr_o   = addr_q;
    assign wb_dat_o    = wdat_q;
    assign wb_sel_o    = !wb_cyc_o ? '0 : (we_q ? wsel_q : '1);
    assign last_beat   = (cnt_q == '0);
    assign wb_cti_o    = (!wb_cyc_o || single_q) ? 3'b000 : (last_beat ? 3'b111 : 3'b010);
    assign beat_ack    = wb_stb_o & wb_ack_i;
    assign rdata       = wb_dat_i;
    assign rdata_valid = beat_ack & ~we_q;
    assign rdata_last  = rdata_valid & last_beat;
    assign done        = done_q;
    assign err         = err_q;
    assign to_hit      = (TO > 0) && wb_stb_o && !wb_ack_i && (to_q == TO_LAST);

    // The first write beat may load together with the command; the final ack never
    // opens the holding register so no data leaks into the next burst.
    always_comb begin
        wdata_ready = 1'b0;
        if (state_q == IDLE) begin
            wdata_ready = cmd_valid & cmd_we & ~reset;
        end else if (we_q) begin
            wdata_ready = ~wfull_q | (beat_ack & ~last_beat);
        end
    end

    assign wload = wdata_valid & wdata_ready;

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        single_d = single_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        wdat_d   = wdat_q;
        wsel_d   = wsel_q;
        wfull_d  = wfull_q;
        to_d     = to_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        if (wload) begin
            wdat_d = wdata;
            wsel_d = wsel;
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    we_d     = cmd_we;
                    addr_d   = cmd_addr;
                    cnt_d    = cmd_len;
                    single_d = (cmd_len == '0);
                    to_d     = '0;
                    wfull_d  = wload;
                    state_d  = (cmd_we && !wload) ? STALL : BURST;
                end
            end
            BURST: begin
                if (beat_ack) begin
                    to_d = '0;
                    if (last_beat) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        wfull_d = 1'b0;
                    end else begin
                        cnt_d  = cnt_q - 1'b1;
                        addr_d = addr_q + STEP;
                        if (we_q) begin
                            wfull_d = wload;
                            if (!wload) state_d = STALL;
                        end
                    end
                end else if (to_hit) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    wfull_d = 1'b0;
                    to_d    = '0;
                end else if (TO > 0) begin
                    to_d = to_q + 1'b1;
                end
            end
            STALL: begin
                if (wload) begin
                    wfull_d = 1'b1;
                    to_d    = '0;
                    state_d = BURST;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            single_q <= 1'b0;
            addr_q   <= '0;
            cnt_q    <= '0;
            wdat_q   <= '0;
            wsel_q   <= '0;
            wfull_q  <= 1'b0;
            to_q     <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            single_q <= single_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            wdat_q   <= wdat_d;
            wsel_q   <= wsel_d;
            wfull_q  <= wfull_d;
            to_q     <= to_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_wb_burst_master.sv
// Self-checking bench for wb_burst_master: reset/idle vector table, directed burst
// scenarios and randomized bursts against a beat-level transaction model.
module tb_wb_burst_master;

    localparam int DW = 32;
    localparam int AW = 26;
    localparam int BL = 5;
    localparam int TO = 4;

    logic          sys_clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [BL-1:0] cmd_len;
    logic [DW-1:0] wdata;
    logic [3:0]    wsel;
    logic          wdata_valid, wdata_ready;
    logic [DW-1:0] rdata;
    logic          rdata_valid, rdata_last, done, err;
    logic          wb_cyc_o, wb_stb_o, wb_we_o;
    logic [AW-1:0] wb_addr_o;
    logic [DW-1:0] wb_dat_o;
    logic [3:0]    wb_sel_o;
    logic [2:0]    wb_cti_o;
    logic          wb_ack_i;
    logic [DW-1:0] wb_dat_i;

    wb_burst_master #(.DW(DW), .AW(AW), .BL(BL), .TO(TO)) dut (
        .sys_clk(sys_clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata(wdata), .wsel(wsel), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .rdata(rdata), .rdata_valid(rdata_valid), .rdata_last(rdata_last),
        .done(done), .err(err),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Per-burst scenario knobs and observation logs.
    int            ack_dly[32];
    int            data_gap[32];
    logic [31:0]   wd[32];
    logic [3:0]    ws[32];
    logic [AW-1:0] log_addr[$];
    logic [2:0]    log_cti[$];
    logic [31:0]   log_dat[$];
    int            stall_seen, done_seen, err_seen;

    task automatic set_defaults();
        for (int i = 0; i < 32; i++) begin
            ack_dly[i]  = 0;
            data_gap[i] = 0;
            wd[i]       = $urandom;
            ws[i]       = 4'($urandom_range(0, 15));
        end
        log_addr.delete();
        log_cti.delete();
        log_dat.delete();
        stall_seen = 0;
        done_seen  = 0;
        err_seen   = 0;
    endtask

    // Transaction model: beat i of a burst goes to addr+4*i with cti 010/111 (000 for
    // single), a write beat is only presented once its data has been handed over,
    // and four consecutive unacknowledged strobe cycles abort the burst.
    task automatic run_burst(input logic we, input logic [AW-1:0] addr, input int len);
        int            beat, loaded, waited, gap, cyc_n;
        logic          active, exp_done, exp_err, ack, stb_e, rdy_e;
        logic [AW-1:0] ea;
        logic [2:0]    ecti;
        beat = 0; loaded = 0; waited = 0; gap = 0; cyc_n = 0;

        @(negedge sys_clk);
        cmd_valid   = 1'b1;
        cmd_we      = we;
        cmd_addr    = addr;
        cmd_len     = 5'(len);
        wdata_valid = we && (data_gap[0] == 0);
        wdata       = wd[0];
        wsel        = ws[0];
        wb_ack_i    = 1'($urandom_range(0, 1));
        wb_dat_i    = $urandom;
        #1;
        chk("accept_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("accept_cyc", 64'(wb_cyc_o), 64'(0));
        chk("accept_wdata_ready", 64'(wdata_ready), 64'(we));
        chk("accept_done", 64'(done), 64'(0));
        if (wdata_valid) loaded = 1; else gap = 1;
        active = 1'b1; exp_done = 1'b0; exp_err = 1'b0;

        while ((active || exp_done || exp_err) && cyc_n < 1000) begin
            @(negedge sys_clk);
            cmd_valid = 1'b0;
            cmd_we    = 1'($urandom_range(0, 1));
            cmd_addr  = AW'($urandom);
            cmd_len   = 5'($urandom_range(0, 31));
            stb_e = active && (!we || loaded > beat);
            wdata_valid = we && active && (loaded <= len) && (gap >= data_gap[loaded <= len ? loaded : 0]);
            wdata = wd[loaded <= len ? loaded : 0];
            wsel  = ws[loaded <= len ? loaded : 0];
            if (stb_e) ack = (waited == ack_dly[beat]);
            else       ack = 1'($urandom_range(0, 1));
            wb_ack_i = ack;
            wb_dat_i = $urandom;
            rdy_e = active && we && (loaded == beat || (loaded == beat + 1 && stb_e && ack && beat < len));
            #1;
            chk("cyc", 64'(wb_cyc_o), 64'(active));
            chk("stb", 64'(wb_stb_o), 64'(stb_e));
            chk("cmd_ready", 64'(cmd_ready), 64'(!active));
            chk("done", 64'(done), 64'(exp_done));
            chk("err", 64'(err), 64'(exp_err));
            chk("wdata_ready", 64'(wdata_ready), 64'(rdy_e));
            chk("rdata_valid", 64'(rdata_valid), 64'(stb_e && ack && !we));
            if (wb_cyc_o && !wb_stb_o) stall_seen++;
            if (done) done_seen++;
            if (err) err_seen++;
            if (stb_e) begin
                ea   = addr + AW'(4 * beat);
                ecti = (len == 0) ? 3'b000 : ((beat == len) ? 3'b111 : 3'b010);
                chk("addr", 64'(wb_addr_o), 64'(ea));
                chk("cti", 64'(wb_cti_o), 64'(ecti));
                chk("we", 64'(wb_we_o), 64'(we));
                chk("sel", 64'(wb_sel_o), we ? 64'(ws[beat]) : 64'(4'hF));
                if (we) chk("wb_dat", 64'(wb_dat_o), 64'(wd[beat]));
                if (ack && !we) begin
                    chk("rdata", 64'(rdata), 64'(wb_dat_i));
                    chk("rdata_last", 64'(rdata_last), 64'(beat == len));
                end
            end
            exp_done = 1'b0;
            exp_err  = 1'b0;
            if (wdata_valid && rdy_e) begin
                loaded++;
                gap = 0;
            end else if (we && active) begin
                gap++;
            end
            if (stb_e && ack) begin
                log_addr.push_back(wb_addr_o);
                log_cti.push_back(wb_cti_o);
                log_dat.push_back(wb_dat_o);
                if (beat == len) begin
                    active   = 1'b0;
                    exp_done = 1'b1;
                end
                beat++;
                waited = 0;
            end else if (stb_e) begin
                waited++;
                if (waited == TO) begin
                    active  = 1'b0;
                    exp_err = 1'b1;
                end
            end
            cyc_n++;
        end
        chk("burst_cycle_bound", 64'(cyc_n < 1000), 64'(1));
        wb_ack_i    = 1'b0;
        wdata_valid = 1'b0;
    endtask

    typedef struct {
        logic       rst, cv, cwe, wv, ack;
        logic       e_cr, e_wr, e_cyc, e_stb, e_rv;
        logic [2:0] e_cti;
    } vec_t;

    vec_t vt[6];

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{rst:1, cv:1, cwe:1, wv:1, ack:1, e_cr:1, e_wr:0, e_cyc:0, e_stb:0, e_rv:0, e_cti:3'b000};
        vt[1] = '{rst:1, cv:0, cwe:0, wv:0, ack:1, e_cr:1, e_wr:0, e_cyc:0, e_stb:0, e_rv:0, e_cti:3'b000};
        vt[2] = '{rst:1, cv:1, cwe:0, wv:1, ack:0, e_cr:1, e_wr:0, e_cyc:0, e_stb:0, e_rv:0, e_cti:3'b000};
        vt[3] = '{rst:0, cv:0, cwe:1, wv:1, ack:1, e_cr:1, e_wr:0, e_cyc:0, e_stb:0, e_rv:0, e_cti:3'b000};
        vt[4] = '{rst:0, cv:0, cwe:0, wv:0, ack:1, e_cr:1, e_wr:0, e_cyc:0, e_stb:0, e_rv:0, e_cti:3'b000};
        vt[5] = '{rst:0, cv:0, cwe:0, wv:1, ack:0, e_cr:1, e_wr:0, e_cyc:0, e_stb:0, e_rv:0, e_cti:3'b000};

        reset = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
        wdata = '0; wsel = '0; wdata_valid = 1'b0; wb_ack_i = 1'b0; wb_dat_i = '0;
        set_defaults();
        repeat (2) @(posedge sys_clk);

        @(negedge sys_clk); #1;
        chk("rst_addr", 64'(wb_addr_o), 64'(0));
        chk("rst_dat", 64'(wb_dat_o), 64'(0));
        chk("rst_sel", 64'(wb_sel_o), 64'(0));
        chk("rst_we", 64'(wb_we_o), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_rdata_last", 64'(rdata_last), 64'(0));
        chk("rst_wdata_ready", 64'(wdata_ready), 64'(0));

        for (int i = 0; i < 6; i++) begin
            @(negedge sys_clk);
            reset = vt[i].rst; cmd_valid = vt[i].cv; cmd_we = vt[i].cwe;
            wdata_valid = vt[i].wv; wb_ack_i = vt[i].ack;
            cmd_addr = AW'($urandom); cmd_len = 5'($urandom_range(0, 31));
            #1;
            chk("vec_cmd_ready", 64'(cmd_ready), 64'(vt[i].e_cr));
            chk("vec_wdata_ready", 64'(wdata_ready), 64'(vt[i].e_wr));
            chk("vec_cyc", 64'(wb_cyc_o), 64'(vt[i].e_cyc));
            chk("vec_stb", 64'(wb_stb_o), 64'(vt[i].e_stb));
            chk("vec_rdata_valid", 64'(rdata_valid), 64'(vt[i].e_rv));
            chk("vec_cti", 64'(wb_cti_o), 64'(vt[i].e_cti));
        end

        // Read burst of four beats with a zero-wait slave.
        set_defaults();
        run_burst(1'b0, 26'h100, 3);
        chk("r046_beats", 64'(log_addr.size()), 64'(4));
        chk("r046_a0", 64'(log_addr[0]), 64'h100);
        chk("r046_a1", 64'(log_addr[1]), 64'h104);
        chk("r046_a2", 64'(log_addr[2]), 64'h108);
        chk("r046_a3", 64'(log_addr[3]), 64'h10C);
        chk("r046_cti0", 64'(log_cti[0]), 64'(3'b010));
        chk("r046_cti3", 64'(log_cti[3]), 64'(3'b111));
        chk("r046_done", 64'(done_seen), 64'(1));

        // Single-beat write.
        set_defaults();
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        run_burst(1'b1, 26'h40, 0);
        chk("r047_cti", 64'(log_cti[0]), 64'(3'b000));
        chk("r047_dat", 64'(log_dat[0]), 64'hDEADBEEF);
        chk("r047_done", 64'(done_seen), 64'(1));

        // Write with second beat's data withheld: five STALL cycles, no error.
        set_defaults();
        data_gap[1] = 5;
        run_burst(1'b1, 26'h2000, 2);
        chk("r048_stall_cycles", 64'(stall_seen), 64'(5));
        chk("r048_err", 64'(err_seen), 64'(0));
        chk("r048_done", 64'(done_seen), 64'(1));

        // Slave never acks: abort after four strobe cycles.
        set_defaults();
        ack_dly[0] = 100;
        run_burst(1'b0, 26'h300, 1);
        chk("r049_err", 64'(err_seen), 64'(1));
        chk("r049_done", 64'(done_seen), 64'(0));
        chk("r049_cmd_ready", 64'(cmd_ready), 64'(1));

        // Address wraps at 2^AW.
        set_defaults();
        run_burst(1'b0, 26'h3FFFFFC, 1);
        chk("r050_a1", 64'(log_addr[1]), 64'(0));

        // Reset during the second beat of a four-beat read.
        @(negedge sys_clk);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 26'h200; cmd_len = 5'd3; wb_ack_i = 1'b0;
        @(negedge sys_clk);
        cmd_valid = 1'b0; wb_ack_i = 1'b1;
        @(negedge sys_clk);
        #1;
        chk("r051_pre_stb", 64'(wb_stb_o), 64'(1));
        chk("r051_pre_addr", 64'(wb_addr_o), 64'h204);
        reset = 1'b1;
        #1;
        chk("r051_cyc", 64'(wb_cyc_o), 64'(0));
        chk("r051_stb", 64'(wb_stb_o), 64'(0));
        chk("r051_done", 64'(done), 64'(0));
        chk("r051_err", 64'(err), 64'(0));
        @(negedge sys_clk);
        wb_ack_i = 1'b0;
        #1;
        chk("r051_hold_done", 64'(done), 64'(0));
        chk("r051_cmd_ready", 64'(cmd_ready), 64'(1));
        reset = 1'b0;
        set_defaults();
        run_burst(1'b1, 26'h500, 2);
        chk("r051_after_done", 64'(done_seen), 64'(1));

        for (int n = 0; n < 30; n++) begin
            logic          rwe;
            int            rlen;
            logic [AW-1:0] raddr;
            set_defaults();
            rwe   = 1'($urandom_range(0, 1));
            rlen  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
            raddr = AW'($urandom) & ~26'h3;
            if (n % 5 == 0) raddr = 26'h3FFFFF0;
            for (int i = 0; i < 32; i++) begin
                ack_dly[i]  = ($urandom_range(0, 19) == 0) ? 6 : int'($urandom_range(0, 3));
                data_gap[i] = int'($urandom_range(0, 3));
            end
            run_burst(rwe, raddr, rlen);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_burst_master.md
WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 Parameter DW, default 32: Wishbone data width in bits, multiple of 8.
REQ-002 Parameter AW, default 26: Wishbone byte-address width.
REQ-003 Parameter BL, default 5: burst-length field width; beats per burst = cmd_len+1, so the maximum is 2^BL.
REQ-004 Parameter TO, default 255: ack timeout in cycles; 0 disables the timeout.
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-006 sys_clk  in  1  clock; all logic is rising-edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 cmd_valid  in  1  command request.
REQ-009 cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
REQ-010 cmd_we  in  1  1 = write burst, 0 = read burst.
REQ-011 cmd_addr  in  AW  burst start byte address, DW/8-aligned.
REQ-012 cmd_len  in  BL  beats minus one.
REQ-013 wdata  in  DW  write beat data.
REQ-014 wsel  in  DW/8  write beat byte enables.
REQ-015 wdata_valid  in  1  write beat available.
REQ-016 wdata_ready  out  1  write beat consumed this cycle.
REQ-017 rdata  out  DW  read beat data.
REQ-018 rdata_valid  out  1  read beat strobe; no backpressure.
REQ-019 rdata_last  out  1  marks the final read beat.
REQ-020 done  out  1  one-cycle pulse when a burst completes normally.
REQ-021 err  out  1  one-cycle pulse when a burst is aborted by timeout.
REQ-022 wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone cycle, strobe and direction.
REQ-023 wb_addr_o  out  AW, wb_dat_o  out  DW, wb_sel_o  out  DW/8, wb_cti_o  out  3: Wishbone address, data, select and cycle type.
REQ-024 wb_ack_i  in  1, wb_dat_i  in  DW: Wishbone acknowledge and read data.

Function
REQ-025 The FSM SHALL have exactly these states: IDLE, BURST, STALL.
REQ-026 cmd_ready SHALL be 1 only in IDLE.
REQ-027 On command accept, the block SHALL latch we, addr and beat count, and go to BURST next cycle with wb_cyc_o=1.
REQ-028 In BURST, wb_stb_o SHALL be 1.
REQ-029 In a write burst in BURST, wb_dat_o/wb_sel_o SHALL be driven from registered write data.
REQ-030 In a read burst, wb_sel_o SHALL be all ones.
REQ-031 A write beat SHALL be loaded into the write registers when wdata_valid & wdata_ready; wdata_ready = 1 when the register is empty or is being acked this cycle.
REQ-032 Write burst with no loaded beat: the FSM SHALL go to STALL, with wb_cyc_o=1 and wb_stb_o=0, and return to BURST the cycle after a beat loads.
REQ-033 Each wb_ack_i while wb_stb_o=1 SHALL decrement the beat counter and advance wb_addr_o by DW/8, modulo 2^AW.
REQ-034 wb_ack_i while wb_stb_o=0 SHALL be ignored.
REQ-035 wb_cti_o SHALL be 3'b010 on non-final beats and 3'b111 on the final beat.
REQ-036 A single-beat burst (cmd_len=0) SHALL use wb_cti_o=3'b000.
REQ-037 Read: rdata SHALL equal wb_dat_i and rdata_valid = wb_ack_i & wb_stb_o & ~wb_we_o, combinationally, zero latency.
REQ-038 rdata_last SHALL be 1 with the final beat's rdata_valid.
REQ-039 On the final beat's ack, the block SHALL pulse done next cycle, drop wb_cyc_o/wb_stb_o, and return to IDLE; back-to-back commands therefore have at least 1 idle cycle between cycles.
REQ-040 Timeout (TO>0): a counter SHALL increment each cycle wb_stb_o=1 & ~wb_ack_i and clear on ack or on entry to BURST.
REQ-041 When the timeout counter reaches TO, the block SHALL drop wb_cyc_o/wb_stb_o next cycle, pulse err, discard remaining beats and any held write data, and return to IDLE; done SHALL NOT pulse.
REQ-042 STALL cycles SHALL NOT count toward the timeout.
REQ-043 An ack in the same cycle as the timeout count reaching TO SHALL take priority: the beat completes and the counter clears.

Reset
REQ-044 While reset=1, the FSM SHALL be IDLE, the beat and timeout counters and write holding register SHALL be cleared, and all outputs SHALL be 0 except cmd_ready=1 and wb_cti_o=3'b000.
REQ-045 Reset mid-burst SHALL deassert wb_cyc_o/wb_stb_o asynchronously, with no done or err pulse.

Verification
REQ-046 Read, addr=0x100, len=3, slave acks every cycle -> addresses 0x100,0x104,0x108,0x10C; cti 010,010,010,111; 4 rdata_valid with last on 4th; done 1 cycle after.
REQ-047 Write, len=0, wdata=0xDEADBEEF, wsel=0xF -> one beat, cti=000, wb_dat_o=0xDEADBEEF, done pulses.
REQ-048 Write, len=2, wdata_valid withheld 5 cycles after beat 1 -> STALL with cyc=1, stb=0; no err; burst completes after data arrives.
REQ-049 TO=4, read len=1, slave never acks -> err pulses after 4 stb cycles; cyc drops; cmd_ready=1; no done.
REQ-050 Read burst, addr=0x3FFFFFC (AW=26), len=1 -> second address 0x0000000.
REQ-051 reset asserted on beat 2 of 4 -> cyc/stb low immediately; after release, a new command is accepted normally.
